seg7_scan_mux: RTL and testbench
================================

# seg7_scan_mux

Time-multiplexed scan driver for a common-anode multi-digit 7-segment display. It sits directly upstream of the BCD-to-segment decoder. The decoder takes a 4-bit `num` and emits active-low segments, blanking for any value 10..15. This block holds a frame-coherent snapshot of all digit values and cycles through the digits at a programmable slot rate. Per slot it presents one nibble on `num_out` for the decoder, plus the matching active-low digit select with dead-time and leading-zero blanking.

## Interface
- `DIGITS`, default 4: number of display digits, legal range 1..8.
- `SCAN_DIV`, default 50000: clk cycles per digit slot; must be > `BLANK_CYC`.
- `BLANK_CYC`, default 16: dead-time cycles at the start of each slot, during which all digits are off; 0 is legal.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `digits_in`  in  4*DIGITS: digit values; nibble i (bits 4i+3:4i) is digit i, and digit 0 is least significant.
- `dp_in`  in  DIGITS: active-high decimal point request per digit.
- `lz_blank_en`  in  1: enables leading-zero blanking.
- `num_out`  out  4: nibble to the decoder; 4'hF means blank.
- `dp_n`  out  1: active-low decimal point for the current digit.
- `dig_sel_n`  out  DIGITS: active-low digit enables; at most one bit is low.
- `frame_tick`  out  1: one-cycle pulse marking the snapshot load.

## Operation
- State registers:
  - `cnt`: slot counter, width $clog2(SCAN_DIV), range 0..SCAN_DIV-1.
  - `idx`: current digit, range 0..DIGITS-1.
  - `snap`: 4*DIGITS-bit digit snapshot.
  - `dps`: DIGITS-bit decimal-point snapshot.
- Every cycle `cnt` increments. When `cnt == SCAN_DIV-1`:
  - `cnt` wraps to 0.
  - `idx` advances; `DIGITS-1` wraps to 0.
- Frame end is the cycle with `cnt == SCAN_DIV-1` and `idx == DIGITS-1`. In that cycle:
  - `frame_tick = 1`.
  - `snap <= digits_in` and `dps <= dp_in`, sampled in that same cycle.
- `snap` and `dps` change only at frame end or reset. Input changes mid-frame are never displayed until the next frame (no tearing).
- Leading-zero blanking, when `lz_blank_en = 1`:
  - Digit i is blanked if its nibble is 0 and every more-significant snapshot nibble is also 0.
  - Digit 0 is never blanked, so an all-zero value shows "0".
  - A blanked digit drives `num_out = 4'hF` and `dp_n = 1`.
- Nibbles 10..15 pass through unchanged; the decoder blanks them.
- `num_out` = snap nibble `idx`, or 4'hF if that digit is blanked.
- `dp_n` = ~`dps[idx]`, forced to 1 during dead time or when the digit is blanked.
- `dig_sel_n`:
  - All ones while `cnt < BLANK_CYC`.
  - Otherwise only bit `idx` is low.
- Outputs are combinational decodes of the registered state only. No input reaches an output combinationally, except `digits_in`/`dp_in` reaching the snapshot at frame end.

## Timing
- Reset, while `rst` is sampled high:
  - next state: `cnt = 0`, `idx = 0`, `snap` = all nibbles 4'hF, `dps = 0`.
  - resulting outputs: `num_out = 4'hF`, `dp_n = 1`, `frame_tick = 0`, and `dig_sel_n` all ones (dead time, since `cnt = 0`).
- Reset mid-scan takes effect the next edge, regardless of `cnt`/`idx`. The display is blank until the first frame end after reset.
- Let k be the cycle count after reset release, with k = 0 as the first cycle out of reset:
  - `cnt = k mod SCAN_DIV`.
  - `idx = (k / SCAN_DIV) mod DIGITS`.
  - The first `frame_tick` is at k = SCAN_DIV*DIGITS - 1.
- Snapshot latency: a value sampled at frame end appears on digit 0 at the next cycle, muted by the dead time. It appears on digit i at slot i of that frame.
- With `DIGITS = 1`, every slot end is a frame end.
- If `BLANK_CYC = 0`, there is no dead time.

## Test plan
Parameters for all scenarios: DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
- **Reset and first frame.** Hold `rst` 3 cycles, then release, with `digits_in = 16'h1234`.
  - k=0..1: `dig_sel_n = 4'b1111`.
  - k=2..7: `dig_sel_n = 4'b1110` with `num_out = 4'hF`.
  - `frame_tick` = 1 only at k=31.
- **Normal scan.** `digits_in = 16'h1234`, `lz_blank_en = 0`, second frame.
  - Slot contents in order: 4, 3, 2, 1.
  - After dead time, `dig_sel_n` is 1110, 1101, 1011, 0111 respectively.
- **Leading-zero blanking.**
  - `16'h0050`, `lz_blank_en = 1` → slots show 0, 5, F, F (idx 0..3).
  - `16'h0000` → slots show 0, F, F, F.
  - `16'h0000` with `lz_blank_en = 0` → slots show 0, 0, 0, 0.
- **No tearing.** Change `digits_in` from 16'h1234 to 16'h9876 at idx=1, cnt=3.
  - Slots 2 and 3 still show 2 and 1.
  - 9876 appears only after the next `frame_tick`.
- **Reset mid-scan.** Assert `rst` at idx=2, cnt=5.
  - Next cycle: `cnt = 0`, `idx = 0`, `dig_sel_n = 4'b1111`, `num_out = 4'hF`.
  - Blank until k=31.
- **Decimal point and invalid nibble.** `dp_in = 4'b0010`, `digits_in = 16'hA000`, `lz_blank_en = 0`.
  - `dp_n = 0` only in slot idx 1 at cnt 2..7.
  - Slot 3 shows `num_out = 4'hA`.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// Scan driver for a common-anode multi-digit 7-segment display: frame-coherent digit
// snapshot, per-slot dead time, leading-zero blanking, and one nibble per slot to the decoder.
module seg7_scan_mux #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_blank_en,
    output logic [3:0]            num_out,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     dig_sel_n,
    output logic                  frame_tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [4*DIGITS-1:0] snap_reg, snap_next;
    logic [DIGITS-1:0]   dps_reg, dps_next;
    logic                lz_reg, lz_next;

    logic slot_end;
    logic frame_end;
    logic dead;

    assign slot_end  = (cnt_reg == CNT_LAST);
    assign frame_end = slot_end && (idx_reg == IDX_LAST);

    // The blanking enable is captured with the digits so a frame never mixes two modes.
    always_comb begin
        cnt_next  = slot_end ? '0 : cnt_reg + CNT_W'(1);
        idx_next  = idx_reg;
        if (slot_end) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
        end
        snap_next = frame_end ? digits_in   : snap_reg;
        dps_next  = frame_end ? dp_in       : dps_reg;
        lz_next   = frame_end ? lz_blank_en : lz_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            idx_reg  <= '0;
            snap_reg <= '1;
            dps_reg  <= '0;
            lz_reg   <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            idx_reg  <= idx_next;
            snap_reg <= snap_next;
            dps_reg  <= dps_next;
            lz_reg   <= lz_next;
        end
    end

    generate
        if (BLANK_CYC == 0) begin : g_no_dead
            assign dead = 1'b0;
        end else begin : g_dead
            assign dead = (cnt_reg < CNT_W'(BLANK_CYC));
        end
    endgenerate

    // zero_run[i]: snapshot nibbles i..DIGITS-1 are all zero.
    logic [DIGITS:0]   zero_run;
    logic [DIGITS-1:0] blank;

    assign zero_run[DIGITS] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign zero_run[gi] = (snap_reg[4*gi +: 4] == 4'h0) && zero_run[gi+1];
            if (gi == 0) begin : g_lsd
                assign blank[gi] = 1'b0;
            end else begin : g_upper
                assign blank[gi] = lz_reg && zero_run[gi];
            end
            assign dig_sel_n[gi] = dead || (idx_reg != IDX_W'(gi));
        end
    endgenerate

    logic [3:0] cur_nib;
    logic       cur_dp;
    logic       cur_blank;

    always_comb begin
        cur_nib   = 4'hF;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                cur_nib   = snap_reg[4*i +: 4];
                cur_dp    = dps_reg[i];
                cur_blank = blank[i];
            end
        end
    end

    assign num_out    = cur_blank ? 4'hF : cur_nib;
    assign dp_n       = dead || cur_blank || !cur_dp;
    assign frame_tick = frame_end;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux: directed scenarios plus random traffic,
// all checked every cycle against a cycle-count based model of the display.
module tb_seg7_scan_mux;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = DIGITS * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        lz_blank_en;
    logic [3:0]  num_out;
    logic        dp_n;
    logic [3:0]  dig_sel_n;
    logic        frame_tick;

    int n_cmp = 0;
    int n_err = 0;

    // Model: k counts cycles since reset release; the snapshot is what the display shows.
    int k = 0;
    int m_snap[DIGITS];
    bit m_dp[DIGITS];
    bit m_lz;

    seg7_scan_mux #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in),
        .lz_blank_en(lz_blank_en), .num_out(num_out), .dp_n(dp_n),
        .dig_sel_n(dig_sel_n), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s k=%0d: got %h expected %h", tag, k, got, exp);
        end
    endtask

    task automatic model_reset();
        k = 0;
        m_lz = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            m_snap[i] = 15;
            m_dp[i]   = 1'b0;
        end
    endtask

    task automatic check_outputs();
        int  slot_cnt, idx;
        bit  dead, blk;
        logic [3:0] e_num, e_sel;
        logic e_dp;
        slot_cnt = k % SCAN_DIV;
        idx      = (k / SCAN_DIV) % DIGITS;
        dead     = (slot_cnt < BLANK_CYC);
        blk      = m_lz && (idx != 0);
        for (int j = idx; j < DIGITS; j++)
            if (m_snap[j] != 0) blk = 1'b0;
        e_num = blk ? 4'hF : 4'(m_snap[idx]);
        e_dp  = (dead || blk) ? 1'b1 : !m_dp[idx];
        e_sel = dead ? 4'hF : ~(4'b0001 << idx);
        check_eq("num_out", 32'(num_out), 32'(e_num));
        check_eq("dp_n", 32'(dp_n), 32'(e_dp));
        check_eq("dig_sel_n", 32'(dig_sel_n), 32'(e_sel));
        check_eq("frame_tick", 32'(frame_tick), 32'((k % FRAME) == FRAME - 1));
    endtask

    // One clock: the model samples the same inputs the DUT sees at the edge.
    task automatic tick();
        bit at_frame_end;
        at_frame_end = ((k % FRAME) == FRAME - 1);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (at_frame_end) begin
                for (int i = 0; i < DIGITS; i++) begin
                    m_snap[i] = int'(digits_in[4*i +: 4]);
                    m_dp[i]   = dp_in[i];
                end
                m_lz = lz_blank_en;
            end
            k++;
        end
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance until the current state is slot idx, count cnt (bounded by two frames).
    task automatic run_to(input int idx, input int slot_cnt);
        int guard;
        guard = 0;
        while ((k % FRAME) != idx * SCAN_DIV + slot_cnt && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
        check_eq("run_to_reached", 32'((k % FRAME) == idx * SCAN_DIV + slot_cnt), 32'd1);
    endtask

    initial begin
        rst         = 1'b1;
        digits_in   = 16'h1234;
        dp_in       = 4'b0000;
        lz_blank_en = 1'b0;
        model_reset();

        // Reset and first frame, then a normal second frame.
        run(3);
        rst = 1'b0;
        run(2 * FRAME);

        // Leading-zero blanking cases; each lasts two frames so the snapshot is shown.
        digits_in = 16'h0050; lz_blank_en = 1'b1; run(2 * FRAME);
        digits_in = 16'h0000;                     run(2 * FRAME);
        lz_blank_en = 1'b0;                       run(2 * FRAME);

        // No tearing: change mid-frame at idx 1, cnt 3.
        digits_in = 16'h1234;
        run_to(0, 0);
        run(FRAME);
        run_to(1, 3);
        digits_in = 16'h9876;
        run(2 * FRAME);

        // Reset mid-scan at idx 2, cnt 5.
        run_to(2, 5);
        rst = 1'b1;
        tick();
        check_eq("mid_rst_sel", 32'(dig_sel_n), 32'hF);
        check_eq("mid_rst_num", 32'(num_out), 32'hF);
        rst = 1'b0;
        run(FRAME + 4);

        // Decimal point and pass-through of an invalid nibble.
        dp_in = 4'b0010; digits_in = 16'hA000; lz_blank_en = 1'b0;
        run(2 * FRAME);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                digits_in   = 16'($urandom);
                if ($urandom_range(0, 2) == 0) digits_in[15:8] = 8'h00;
                if ($urandom_range(0, 3) == 0) digits_in[7:4]  = 4'h0;
                dp_in       = 4'($urandom);
                lz_blank_en = 1'($urandom);
            end
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        run(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
